// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, width and controller state definitions for the ALU sharing block
package alu_pkg;

    localparam int W_DEF   = 8;
    localparam int OPW_DEF = 3;

    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_SUB     = 3'b001;
    localparam logic [2:0] OP_AND     = 3'b010;
    localparam logic [2:0] OP_OR      = 3'b011;
    localparam logic [2:0] OP_XOR     = 3'b100;
    localparam logic [2:0] OP_ILLEGAL = 3'b101;
    localparam logic [2:0] OP_SLT     = 3'b110;
    localparam logic [2:0] OP_BZ      = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_CAPT = 2'b10,
        ST_RESP = 2'b11
    } ctrl_state_e;

    function automatic logic op_is_illegal(input logic [2:0] op);
        return op == OP_ILLEGAL;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter; caller owns the last-grant pointer
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       grant_idx
);

    always_comb begin
        grant     = 2'b00;
        grant_idx = 1'b0;
        if (enable) begin
            // On a tie the requester that was not served last wins.
            if (valid == 2'b11) begin
                grant_idx = ~last;
            end else begin
                grant_idx = valid[1];
            end
            grant = valid & (grant_idx ? 2'b10 : 2'b01);
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - arbitrates two requesters onto one registered ALU and returns results
import alu_pkg::*;

module alu_share_ctrl #(
    parameter int W   = W_DEF,
    parameter int OPW = OPW_DEF
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_op,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,

    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_op,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,

    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic [W-1:0]   rsp0_data,
    output logic           rsp0_zero,
    output logic           rsp0_err,

    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [W-1:0]   rsp1_data,
    output logic           rsp1_zero,
    output logic           rsp1_err,

    output logic [OPW-1:0] alu_op,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    input  logic [W-1:0]   alu_ans,
    input  logic           alu_zero
);

    ctrl_state_e    state;
    ctrl_state_e    state_nxt;
    logic           owner;
    logic           last;
    logic [W-1:0]   data_q;
    logic           zero_q;
    logic           err_q;

    logic           arb_en;
    logic [1:0]     grant;
    logic           gidx;
    logic           hs;
    logic           rsp_hs;
    logic [OPW-1:0] sel_op;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic           sel_illegal;
    logic           is_bz;

    // Ready is masked during reset so the channel reads idle while rst is held.
    assign arb_en = (state == ST_IDLE) && !rst;

    rr_arb2 u_arb (
        .valid     ({req1_valid, req0_valid}),
        .last      (last),
        .enable    (arb_en),
        .grant     (grant),
        .grant_idx (gidx)
    );

    assign req0_ready  = grant[0];
    assign req1_ready  = grant[1];
    assign hs          = |grant;

    assign sel_op      = gidx ? req1_op : req0_op;
    assign sel_a       = gidx ? req1_a  : req0_a;
    assign sel_b       = gidx ? req1_b  : req0_b;
    assign sel_illegal = op_is_illegal(sel_op);
    assign is_bz       = (alu_op == OP_BZ);

    assign rsp_hs      = (state == ST_RESP) && (owner ? rsp1_ready : rsp0_ready);

    assign rsp0_valid  = (state == ST_RESP) && !owner;
    assign rsp1_valid  = (state == ST_RESP) &&  owner;
    assign rsp0_data   = rsp0_valid ? data_q : '0;
    assign rsp0_zero   = rsp0_valid & zero_q;
    assign rsp0_err    = rsp0_valid & err_q;
    assign rsp1_data   = rsp1_valid ? data_q : '0;
    assign rsp1_zero   = rsp1_valid & zero_q;
    assign rsp1_err    = rsp1_valid & err_q;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (hs) begin
                    state_nxt = sel_illegal ? ST_RESP : ST_EXEC;
                end
            end
            ST_EXEC: state_nxt = ST_CAPT;
            ST_CAPT: state_nxt = ST_RESP;
            ST_RESP: begin
                if (rsp_hs) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            owner  <= 1'b0;
            last   <= 1'b1;
            data_q <= '0;
            zero_q <= 1'b0;
            err_q  <= 1'b0;
            alu_op <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                owner <= gidx;
                last  <= gidx;
                // Illegal ops never reach the ALU, so its operands keep the previous op.
                if (sel_illegal) begin
                    data_q <= '0;
                    zero_q <= 1'b0;
                    err_q  <= 1'b1;
                end else begin
                    alu_op <= sel_op;
                    alu_a  <= sel_a;
                    alu_b  <= sel_b;
                end
            end
            if (state == ST_CAPT) begin
                data_q <= is_bz ? '0 : alu_ans;
                zero_q <= is_bz ? alu_zero : 1'b0;
                err_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - self-checking bench for alu_share_ctrl with a registered ALU stand-in
import alu_pkg::*;

module tb_alu_share_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
    logic       rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
    logic [7:0] rsp0_data, rsp1_data;
    logic [2:0] alu_op;
    logic [7:0] alu_a, alu_b;
    logic [7:0] alu_ans = 8'h00;
    logic       alu_zero = 1'b0;
    logic [7:0] stub_res;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.W(8), .OPW(3)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_ans(alu_ans), .alu_zero(alu_zero)
    );

    // ALU stand-in: one-cycle registered result; zero flag reflects the raw result for non-BZ ops.
    always_comb begin
        case (alu_op)
            3'b000:  stub_res = alu_a + alu_b;
            3'b001:  stub_res = alu_a - alu_b;
            3'b010:  stub_res = alu_a & alu_b;
            3'b011:  stub_res = alu_a | alu_b;
            3'b100:  stub_res = alu_a ^ alu_b;
            3'b110:  stub_res = {7'd0, alu_a < alu_b};
            3'b111:  stub_res = alu_a;
            default: stub_res = 8'hA5;
        endcase
    end

    always @(posedge clk) begin
        alu_ans  <= stub_res;
        alu_zero <= (alu_op == 3'b111) ? (alu_a == 8'h00) : (stub_res == 8'h00);
    end

    function automatic logic [9:0] ref_rsp(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int   ia, ib, r;
        logic z, e;
        ia = a; ib = b; r = 0; z = 1'b0; e = 1'b0;
        case (op)
            3'b000:  r = (ia + ib) % 256;
            3'b001:  r = (ia - ib + 256) % 256;
            3'b010:  r = ia & ib;
            3'b011:  r = ia | ib;
            3'b100:  r = ia ^ ib;
            3'b110:  r = (ia < ib) ? 1 : 0;
            3'b111:  z = (ia == 0);
            default: e = 1'b1;
        endcase
        return {e, z, r[7:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input int p, input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        if (p == 1) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    function automatic logic rsp_v(input int p);
        return (p == 1) ? rsp1_valid : rsp0_valid;
    endfunction

    function automatic logic [9:0] rsp_pl(input int p);
        return (p == 1) ? {rsp1_err, rsp1_zero, rsp1_data} : {rsp0_err, rsp0_zero, rsp0_data};
    endfunction

    // Called the cycle after a handshake; waits for the response and checks latency and payload.
    task automatic wait_rsp(input int p, input logic [7:0] d, input logic z, input logic e, input string tag);
        int lat;
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) drive_req(p, 1'b0, 3'b000, 8'h00, 8'h00);
            #1;
            if (rsp_v(p)) begin
                lat = k;
                break;
            end
            check({tag, " stall"}, {req0_ready, req1_ready}, 2'b00);
        end
        check({tag, " latency"}, lat, e ? 1 : 3);
        check({tag, " payload"}, rsp_pl(p), {e, z, d});
        check({tag, " other rsp"}, rsp_v(1 - p), 1'b0);
        check({tag, " ready in resp"}, {req0_ready, req1_ready}, 2'b00);
    endtask

    task automatic run_single(input int p, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] d, input logic z, input logic e, input string tag);
        @(negedge clk);
        drive_req(p, 1'b1, op, a, b);
        #1;
        check({tag, " ready"}, {req1_ready, req0_ready}, (p == 1) ? 2'b10 : 2'b01);
        wait_rsp(p, d, z, e, tag);
        @(negedge clk);
        #1;
        check({tag, " drop"}, {rsp0_valid, rsp1_valid}, 2'b00);
    endtask

    // req0: SUB 5-7 = FE, req1: SLT 3<9 = 01, both presented in the same IDLE cycle.
    task automatic run_pair(input int w, input string tag);
        int         l;
        logic [7:0] dw, dl;
        l  = 1 - w;
        dw = (w == 1) ? 8'h01 : 8'hFE;
        dl = (l == 1) ? 8'h01 : 8'hFE;
        @(negedge clk);
        drive_req(0, 1'b1, OP_SUB, 8'd5, 8'd7);
        drive_req(1, 1'b1, OP_SLT, 8'd3, 8'd9);
        #1;
        check({tag, " grant"}, {req1_ready, req0_ready}, (w == 1) ? 2'b10 : 2'b01);
        wait_rsp(w, dw, 1'b0, 1'b0, {tag, " first"});
        @(negedge clk);
        #1;
        check({tag, " loser grant"}, {req1_ready, req0_ready}, (l == 1) ? 2'b10 : 2'b01);
        wait_rsp(l, dl, 1'b0, 1'b0, {tag, " second"});
        @(negedge clk);
        #1;
        check({tag, " drop"}, {rsp0_valid, rsp1_valid}, 2'b00);
    endtask

    typedef struct {
        int         p;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       z;
        logic       e;
    } vec_t;

    vec_t       vt[9];
    logic [2:0] prev_op;
    logic [7:0] prev_a, prev_b;

    bit         pv[2];
    logic [2:0] pop[2];
    logic [7:0] pa[2], pb[2];
    bit         rr[2];
    bit         busy;
    int         owner, mlast, resp_at, g;
    logic [9:0] exp_r;
    bit         ev;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vt[0] = '{0, OP_ADD,     8'hF0, 8'h20, 8'h10, 1'b0, 1'b0};
        vt[1] = '{1, OP_BZ,      8'h00, 8'h55, 8'h00, 1'b1, 1'b0};
        vt[2] = '{1, OP_BZ,      8'h04, 8'h00, 8'h00, 1'b0, 1'b0};
        vt[3] = '{0, OP_XOR,     8'h0F, 8'hFF, 8'hF0, 1'b0, 1'b0};
        vt[4] = '{1, OP_AND,     8'h3C, 8'h0F, 8'h0C, 1'b0, 1'b0};
        vt[5] = '{0, OP_OR,      8'h50, 8'h05, 8'h55, 1'b0, 1'b0};
        vt[6] = '{1, OP_SLT,     8'hFF, 8'h01, 8'h00, 1'b0, 1'b0};
        vt[7] = '{0, OP_SUB,     8'h00, 8'h01, 8'hFF, 1'b0, 1'b0};
        vt[8] = '{0, OP_ILLEGAL, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1};

        rst = 1'b1;
        drive_req(0, 1'b1, OP_ADD, 8'h11, 8'h22);
        drive_req(1, 1'b1, OP_ADD, 8'h33, 8'h44);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset alu regs", {alu_op, alu_a, alu_b}, 19'd0);
        check("reset handshake outs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                                       rsp0_zero, rsp0_err, rsp1_zero, rsp1_err}, 8'd0);
        check("reset rsp data", {rsp0_data, rsp1_data}, 16'd0);
        @(negedge clk);
        drive_req(0, 1'b0, 3'b000, 8'h00, 8'h00);
        drive_req(1, 1'b0, 3'b000, 8'h00, 8'h00);
        rst = 1'b0;

        run_pair(0, "pair1");
        run_single(0, OP_ADD, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b0, "add wrap");
        run_pair(1, "pair2");

        prev_op = 3'b000; prev_a = 8'h00; prev_b = 8'h00;
        for (int i = 0; i < 9; i++) begin
            run_single(vt[i].p, vt[i].op, vt[i].a, vt[i].b, vt[i].d, vt[i].z, vt[i].e, $sformatf("vec%0d", i));
            if (vt[i].e) begin
                check($sformatf("vec%0d alu hold", i), {alu_op, alu_a, alu_b}, {prev_op, prev_a, prev_b});
            end else begin
                prev_op = vt[i].op; prev_a = vt[i].a; prev_b = vt[i].b;
            end
        end

        // Backpressure on rsp0 while req1 waits.
        rsp0_ready = 1'b0;
        @(negedge clk);
        drive_req(0, 1'b1, OP_ADD, 8'h01, 8'h02);
        #1;
        check("bp accept", req0_ready, 1'b1);
        @(negedge clk);
        drive_req(0, 1'b0, 3'b000, 8'h00, 8'h00);
        drive_req(1, 1'b1, OP_XOR, 8'hAA, 8'h55);
        #1;
        check("bp exec ready1", req1_ready, 1'b0);
        @(negedge clk);
        #1;
        check("bp capt ready1", req1_ready, 1'b0);
        @(negedge clk);
        #1;
        check("bp rsp at T+3", rsp0_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("bp hold%0d", i), {rsp0_valid, rsp0_data, rsp0_err, req1_ready}, {1'b1, 8'h03, 1'b0, 1'b0});
        end
        @(negedge clk);
        rsp0_ready = 1'b1;
        #1;
        check("bp release cycle", {rsp0_valid, req1_ready}, 2'b10);
        @(negedge clk);
        #1;
        check("bp req1 accepted", {rsp0_valid, req1_ready}, 2'b01);
        wait_rsp(1, 8'hFF, 1'b0, 1'b0, "bp req1");
        @(negedge clk);
        #1;
        check("bp drop", {rsp0_valid, rsp1_valid}, 2'b00);

        // Reset while the XOR is in EXEC: the op is abandoned.
        @(negedge clk);
        drive_req(0, 1'b1, OP_XOR, 8'h3C, 8'h0F);
        #1;
        check("abort accept", req0_ready, 1'b1);
        @(negedge clk);
        drive_req(0, 1'b0, 3'b000, 8'h00, 8'h00);
        #1;
        rst = 1'b1;
        #1;
        check("abort alu regs", {alu_op, alu_a, alu_b}, 19'd0);
        check("abort outs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp0_err}, 13'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("abort no rsp%0d", i), {rsp0_valid, rsp1_valid}, 2'b00);
        end
        run_pair(0, "post reset");

        // Randomized traffic against a cycle-count model of the sharing rules.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        busy = 1'b0; mlast = 1; owner = 0; resp_at = 0; exp_r = '0;
        pv[0] = 1'b0; pv[1] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (!pv[p]) begin
                    pv[p]  = ($urandom % 3) != 0;
                    pop[p] = 3'($urandom % 8);
                    pa[p]  = 8'($urandom);
                    pb[p]  = ($urandom % 4 == 0) ? pa[p] : 8'($urandom);
                end
                rr[p] = ($urandom % 4) != 0;
                drive_req(p, pv[p], pop[p], pa[p], pb[p]);
            end
            rsp0_ready = rr[0];
            rsp1_ready = rr[1];
            #1;
            g = -1;
            if (!busy) begin
                if (pv[0] && pv[1]) g = 1 - mlast;
                else if (pv[0])     g = 0;
                else if (pv[1])     g = 1;
            end
            ev = busy && (c >= resp_at);
            check($sformatf("rand%0d ready", c), {req1_ready, req0_ready}, {g == 1, g == 0});
            check($sformatf("rand%0d rsp valid", c), {rsp1_valid, rsp0_valid}, {ev && owner == 1, ev && owner == 0});
            if (ev) begin
                check($sformatf("rand%0d payload", c), rsp_pl(owner), exp_r);
            end
            if (ev && rr[owner]) begin
                busy = 1'b0;
            end else if (g >= 0) begin
                busy    = 1'b1;
                owner   = g;
                mlast   = g;
                exp_r   = ref_rsp(pop[g], pa[g], pb[g]);
                resp_at = c + (exp_r[9] ? 1 : 3);
                pv[g]   = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Shares the single 8-bit registered ALU between two requesters (e.g. datapath issue slot and address/branch unit).
- Round-robin arbitration over valid/ready request channels.
- Sequences each operation through the ALU's one-cycle registered latency and returns the result on per-requester response channels with backpressure.
- Sits directly in front of the alu instance; owns alu op/a/b, consumes ans/zero.

Parameters:
- W, 8, operand/result width (must match the ALU).
- OPW, 3, opcode width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  controller accepts requester 0 this cycle.
- req0_op  in  OPW  opcode: ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 110, BZ 111.
- req0_a, req0_b  in  W  operands.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0.
- rsp0_valid  out  1  result for requester 0 available.
- rsp0_ready  in  1  requester 0 takes result.
- rsp0_data  out  W  result.
- rsp0_zero  out  1  BZ outcome.
- rsp0_err  out  1  illegal opcode.
- rsp1_valid, rsp1_ready, rsp1_data, rsp1_zero, rsp1_err: same for requester 1.
- alu_op  out  OPW  to ALU, registered.
- alu_a, alu_b  out  W  to ALU, registered.
- alu_ans  in  W  ALU registered result.
- alu_zero  in  1  ALU registered zero flag.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; rr pointer last=1, so req0 wins the first tie.
  - All outputs 0: alu_op=000, alu_a=alu_b=0, both ready=0, all rsp_* =0.
- Reset mid-operation aborts the operation; no response is ever issued for it.
- States: IDLE, EXEC, CAPT, RESP.
- IDLE:
  - grant = the only valid requester; if both are valid, the one != last.
  - reqN_ready = (state==IDLE) && grant==N. It is combinational from valids and last; never asserted outside IDLE.
  - On handshake: latch op/a/b into alu_op/alu_a/alu_b, latch owner=N, last<=N.
  - Legal op -> EXEC. Illegal op (101) -> RESP directly with data=0, zero=0, err=1; the ALU is not used.
- EXEC: alu_* held stable; the ALU registers its result at the end of this cycle. Next state is CAPT.
- CAPT:
  - Latch the result register: data = alu_ans for non-BZ, 0 for BZ.
  - zero = alu_zero for BZ, 0 otherwise; err=0.
  - Next state is RESP.
- RESP:
  - rspN_valid=1 for owner only; data/zero/err held stable while valid.
  - On rspN_ready: valid drops next cycle, state -> IDLE.
  - Valid is held indefinitely without ready. The other requester stalls (ready=0) meanwhile.
- Latency:
  - Handshake in cycle T -> rsp_valid in cycle T+3 for legal ops, T+1 for illegal.
  - Minimum 4 cycles per legal op, since a new accept is possible the cycle after the rsp handshake.
- Width rules: no widening. ADD/SUB wrap modulo 2^W. SLT is an unsigned compare yielding 0/1 zero-extended.
- alu_op/a/b keep their last value between operations. This is required because the ALU clocks every cycle and is harmless to it.
- Simultaneous events:
  - A request is asserted during RESP: not accepted until IDLE.
  - Both requesters are valid at the same IDLE: the loser is guaranteed the next grant if it stays valid (no starvation).

Decomposition:
- Shared package alu_pkg:
  - Opcode constants ADD/SUB/AND/OR/XOR/SLT/BZ and OP_ILLEGAL=101.
  - W/OPW defaults.
  - Controller state encoding (IDLE 00, EXEC 01, CAPT 10, RESP 11).
- One sub-module rr_arb2: 2-input round-robin arbiter.
  - Inputs: valid[1:0], last, enable.
  - Outputs: one-hot grant and grant index.
  - The controller owns the update of last.

Test Plan:
- Reset then req0 ADD a=8'hF0 b=8'h20 (rsp_ready=1) -> req0_ready in the handshake cycle, rsp0_valid 3 cycles later, rsp0_data=8'h10, zero=0, err=0.
- req0 and req1 valid the same cycle, req0 SUB 5-7, req1 SLT 3<9 -> req0 served first with data 8'hFE, then req1 with data 8'h01; a second simultaneous pair is served req1 first.
- req1 BZ a=0 then BZ a=8'h04 -> rsp1_zero=1 then 0, rsp1_data=0 both times.
- req0 op=101 -> rsp0_valid the cycle after the handshake, err=1, data=0; alu_op unchanged from the previous op.
- Hold rsp0_ready=0 for 5 cycles with req1 valid -> rsp0_valid/data stable, req1_ready=0 throughout; release ready -> req1 accepted the next cycle.
- Assert rst during EXEC of a req0 XOR -> all outputs 0 immediately, no rsp0_valid after deassert; the next tie grants req0.
